// File: rtl/python_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// python_pkg : PYTHON kernel-link sync codes and TX state type.   Rev 1.0
// ---------------------------------------------------------------------------
package python_pkg;

   localparam logic [9:0] SYNC_TR  = 10'h3a6;
   localparam logic [9:0] SYNC_FS  = 10'h2aa;
   localparam logic [9:0] SYNC_LS  = 10'h0aa;
   localparam logic [9:0] SYNC_PIX = 10'h035;
   localparam logic [9:0] SYNC_LE  = 10'h12a;
   localparam logic [9:0] SYNC_FE  = 10'h3aa;
   localparam logic [9:0] SYNC_CRC = 10'h059;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LINE   = 2'd1,
      ST_CRC    = 2'd2,
      ST_HBLANK = 2'd3
   } python_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/jelly3_axi4s_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jelly3_axi4s_if : AXI4-Stream video bus with master/slave modports. Rev 1.0
// ---------------------------------------------------------------------------
interface jelly3_axi4s_if #(
   parameter int DATA_BITS = 40
)(
   input wire logic aresetn,
   input wire logic aclk
);
   logic [DATA_BITS-1:0] tdata;
   logic                 tuser;
   logic                 tlast;
   logic                 tvalid;
   logic                 tready;

   modport m (input aresetn, input aclk, output tdata, output tuser, output tlast,
              output tvalid, input tready);
   modport s (input aresetn, input aclk, input tdata, input tuser, input tlast,
              input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/python_lane_checksum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// python_lane_checksum : per-lane XOR line accumulator.           Rev 1.0
// ---------------------------------------------------------------------------
module python_lane_checksum #(
   parameter int DATA_BITS = 10
)(
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_clr,
   input  wire logic                 i_en,
   input  wire logic [DATA_BITS-1:0] i_data,
   output logic      [DATA_BITS-1:0] o_acc
);
   logic [DATA_BITS-1:0] r_acc;

   // clear+enable together restarts the sum with the current word
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_acc <= '0;
      else if (i_clr)
         r_acc <= i_en ? i_data : '0;
      else if (i_en)
         r_acc <= r_acc ^ i_data;
   end

   assign o_acc = r_acc;
endmodule
`default_nettype wire

// File: rtl/axi4s_to_python.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4s_to_python : AXI4-Stream video to PYTHON 4-lane link transmitter. Rev 1.0
// ---------------------------------------------------------------------------
module axi4s_to_python
   import python_pkg::*;
#(
   parameter int DATA_BITS   = 10,
   parameter int LANES       = 4,
   parameter int HEIGHT_BITS = 16,
   parameter int HBLANK_BITS = 16
)(
   input  wire logic                            reset,
   input  wire logic                            clk,
   jelly3_axi4s_if.s                            s_axi4s,
   input  wire logic [HEIGHT_BITS-1:0]          param_height,
   input  wire logic [HBLANK_BITS-1:0]          param_hblank,
   output logic      [LANES-1:0][DATA_BITS-1:0] m_data,
   output logic      [DATA_BITS-1:0]            m_sync,
   output logic                                 m_valid
);
   localparam logic [DATA_BITS-1:0] C_SYNC_TR  = DATA_BITS'(SYNC_TR);
   localparam logic [DATA_BITS-1:0] C_SYNC_FS  = DATA_BITS'(SYNC_FS);
   localparam logic [DATA_BITS-1:0] C_SYNC_LS  = DATA_BITS'(SYNC_LS);
   localparam logic [DATA_BITS-1:0] C_SYNC_PIX = DATA_BITS'(SYNC_PIX);
   localparam logic [DATA_BITS-1:0] C_SYNC_LE  = DATA_BITS'(SYNC_LE);
   localparam logic [DATA_BITS-1:0] C_SYNC_FE  = DATA_BITS'(SYNC_FE);
   localparam logic [DATA_BITS-1:0] C_SYNC_CRC = DATA_BITS'(SYNC_CRC);

   python_tx_state_t                r_state,      w_state_next;
   logic                            r_tready,     w_tready_next;
   logic                            r_frame_open, w_frame_next;
   logic                            r_close,      w_close_next;
   logic [HEIGHT_BITS-1:0]          r_line_cnt,   w_cnt_next;
   logic [HBLANK_BITS-1:0]          r_hb_cnt,     w_hb_next;
   logic [LANES-1:0][DATA_BITS-1:0] r_data,       w_data_next;
   logic [DATA_BITS-1:0]            r_sync,       w_sync_next;
   logic                            r_valid,      w_valid_next;

   logic [LANES-1:0][DATA_BITS-1:0] w_beat;
   logic [LANES-1:0][DATA_BITS-1:0] w_acc;
   logic [HEIGHT_BITS-1:0]          w_cnt_eff;
   logic                            w_accept;
   logic                            w_last_line;
   logic                            w_acc_clr;
   logic                            w_acc_en;
   wire                             w_unused_if = s_axi4s.aclk ^ s_axi4s.aresetn;

   assign w_beat    = s_axi4s.tdata;
   assign w_accept  = s_axi4s.tvalid & r_tready;
   // a frame-start beat sees the counter as already cleared
   assign w_cnt_eff   = (r_state == ST_IDLE && s_axi4s.tuser) ? '0 : r_line_cnt;
   assign w_last_line = (w_cnt_eff == param_height - 1'b1);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         python_lane_checksum #(.DATA_BITS(DATA_BITS)) u_csum (
            .clk    (clk),
            .rst    (reset),
            .i_clr  (w_acc_clr),
            .i_en   (w_acc_en),
            .i_data (w_beat[gi]),
            .o_acc  (w_acc[gi])
         );
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_frame_next = r_frame_open;
      w_close_next = r_close;
      w_cnt_next   = r_line_cnt;
      w_hb_next    = r_hb_cnt;
      w_data_next  = r_data;
      w_sync_next  = r_sync;
      w_valid_next = 1'b0;
      w_acc_clr    = 1'b0;
      w_acc_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_valid_next = 1'b1;
            w_sync_next  = C_SYNC_TR;
            w_data_next  = {LANES{C_SYNC_TR}};
            if (w_accept && (s_axi4s.tuser || r_frame_open)) begin
               w_sync_next  = s_axi4s.tuser ? C_SYNC_FS : C_SYNC_LS;
               w_data_next  = w_beat;
               w_acc_clr    = 1'b1;
               w_acc_en     = 1'b1;
               w_frame_next = 1'b1;
               if (s_axi4s.tuser)
                  w_cnt_next = '0;
               if (s_axi4s.tlast) begin
                  w_state_next = ST_CRC;
                  w_close_next = w_last_line;
                  if (w_last_line)
                     w_frame_next = 1'b0;
               end else begin
                  w_state_next = ST_LINE;
               end
            end
         end
         ST_LINE: begin
            if (w_accept) begin
               w_valid_next = 1'b1;
               w_data_next  = w_beat;
               w_acc_en     = 1'b1;
               w_sync_next  = C_SYNC_PIX;
               if (s_axi4s.tlast) begin
                  w_sync_next  = w_last_line ? C_SYNC_FE : C_SYNC_LE;
                  w_close_next = w_last_line;
                  if (w_last_line)
                     w_frame_next = 1'b0;
                  w_state_next = ST_CRC;
               end
            end
         end
         ST_CRC: begin
            w_valid_next = 1'b1;
            w_sync_next  = C_SYNC_CRC;
            w_data_next  = w_acc;
            w_acc_clr    = 1'b1;
            w_close_next = 1'b0;
            if (r_close)
               w_cnt_next = '0;
            else if (r_line_cnt != {HEIGHT_BITS{1'b1}})
               w_cnt_next = r_line_cnt + 1'b1;
            w_hb_next    = param_hblank;
            w_state_next = (param_hblank == '0) ? ST_IDLE : ST_HBLANK;
         end
         ST_HBLANK: begin
            w_valid_next = 1'b1;
            w_sync_next  = C_SYNC_TR;
            w_data_next  = {LANES{C_SYNC_TR}};
            w_hb_next    = r_hb_cnt - 1'b1;
            if (r_hb_cnt == HBLANK_BITS'(1))
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
      // entering IDLE holds off one cycle so a training word separates lines
      w_tready_next = (w_state_next == ST_LINE) ||
                      (w_state_next == ST_IDLE && r_state == ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tready     <= 1'b0;
         r_frame_open <= 1'b0;
         r_close      <= 1'b0;
         r_line_cnt   <= '0;
         r_hb_cnt     <= '0;
         r_data       <= {LANES{C_SYNC_TR}};
         r_sync       <= C_SYNC_TR;
         r_valid      <= 1'b0;
      end else begin
         r_tready     <= w_tready_next;
         r_frame_open <= w_frame_next;
         r_close      <= w_close_next;
         r_line_cnt   <= w_cnt_next;
         r_hb_cnt     <= w_hb_next;
         r_data       <= w_data_next;
         r_sync       <= w_sync_next;
         r_valid      <= w_valid_next;
      end
   end

   assign s_axi4s.tready = r_tready;
   assign m_data         = r_data;
   assign m_sync         = r_sync;
   assign m_valid        = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_axi4s_to_python.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi4s_to_python : directed vector bench for the PYTHON link TX. Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi4s_to_python;
   localparam int DB = 10;
   localparam int LN = 4;

   typedef struct {
      logic              tvalid;
      logic              tuser;
      logic              tlast;
      logic [LN*DB-1:0]  tdata;
      logic              exp_valid;
      logic [DB-1:0]     exp_sync;
      logic [LN*DB-1:0]  exp_data;
      logic              exp_tready;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [15:0]           param_height;
   logic [15:0]           param_hblank;
   logic [LN-1:0][DB-1:0] m_data;
   logic [DB-1:0]         m_sync;
   logic                  m_valid;
   int                    n_tests = 0;
   int                    n_fail  = 0;
   vec_t                  vecs[$];

   jelly3_axi4s_if #(.DATA_BITS(LN*DB)) axis (.aresetn(~reset), .aclk(clk));

   axi4s_to_python #(.DATA_BITS(DB), .LANES(LN), .HEIGHT_BITS(16), .HBLANK_BITS(16)) dut (
      .reset        (reset),
      .clk          (clk),
      .s_axi4s      (axis),
      .param_height (param_height),
      .param_hblank (param_hblank),
      .m_data       (m_data),
      .m_sync       (m_sync),
      .m_valid      (m_valid)
   );

   always #5 clk = ~clk;

   localparam logic [LN*DB-1:0] TR40 = {4{10'h3a6}};

   task automatic check(input string nm, input logic [LN*DB-1:0] act, input logic [LN*DB-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic tv, input logic tu, input logic tl, input logic [LN*DB-1:0] d,
                      input logic ev, input logic [DB-1:0] es, input logic [LN*DB-1:0] ed,
                      input logic er);
      vec_t v;
      v.tvalid = tv; v.tuser = tu; v.tlast = tl; v.tdata = d;
      v.exp_valid = ev; v.exp_sync = es; v.exp_data = ed; v.exp_tready = er;
      vecs.push_back(v);
   endtask

   // drive one input beat, clock once, compare the registered outputs
   task automatic cyc(input string nm, input logic tv, input logic tu, input logic tl,
                      input logic [LN*DB-1:0] d, input logic ev, input logic [DB-1:0] es,
                      input logic [LN*DB-1:0] ed, input logic er);
      axis.tvalid = tv;
      axis.tuser  = tu;
      axis.tlast  = tl;
      axis.tdata  = d;
      @(posedge clk);
      #1;
      check({nm, ".valid"}, 40'(m_valid), 40'(ev));
      if (ev) begin
         check({nm, ".sync"}, 40'(m_sync), 40'(es));
         check({nm, ".data"}, m_data, ed);
      end
      check({nm, ".tready"}, 40'(axis.tready), 40'(er));
   endtask

   initial begin
      logic [LN*DB-1:0] a0, a1, a2, b0, b1, b2, x0, x1, c0, c1, c2, c3, d0, e0, e1;
      a0 = 40'h01_0203_0405; a1 = 40'h11_2233_4455; a2 = 40'hf0_0f00_ff01;
      b0 = 40'h3f_f000_0001; b1 = 40'h12_3456_789a; b2 = 40'h80_4020_1008;
      x0 = 40'hde_adbe_ef00; x1 = 40'h55_aa55_aa55;
      c0 = 40'h00_0000_0001; c1 = 40'h00_0000_0300; c2 = 40'h70_0000_0000; c3 = 40'h0a_bcde_f012;
      d0 = 40'hca_fe12_3456; e0 = 40'h33_3333_3333; e1 = 40'h44_4444_4444;

      reset = 1'b1;
      axis.tvalid = 1'b0; axis.tuser = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
      param_height = 16'd2;
      param_hblank = 16'd3;
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid",  40'(m_valid), 40'(1'b0));
      check("rst.sync",   40'(m_sync), 40'(10'h3a6));
      check("rst.data",   m_data, TR40);
      check("rst.tready", 40'(axis.tready), 40'(1'b0));
      reset = 1'b0;

      // idle, pre-frame discards, then two 3-beat lines of a 2-line frame
      add(0,0,0,'0, 1,10'h3a6,TR40, 1);
      add(1,0,0,x0, 1,10'h3a6,TR40, 1);
      add(1,0,1,x1, 1,10'h3a6,TR40, 1);
      add(1,1,0,a0, 1,10'h2aa,a0,   1);
      add(1,0,0,a1, 1,10'h035,a1,   1);
      add(1,0,1,a2, 1,10'h12a,a2,   0);
      add(0,0,0,'0, 1,10'h059,a0^a1^a2, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(1,0,0,b0, 1,10'h3a6,TR40, 1);
      add(1,0,0,b0, 1,10'h0aa,b0,   1);
      add(1,0,0,b1, 1,10'h035,b1,   1);
      add(1,0,1,b2, 1,10'h3aa,b2,   0);
      add(0,0,0,'0, 1,10'h059,b0^b1^b2, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(0,0,0,'0, 1,10'h3a6,TR40, 0);
      add(1,0,0,x0, 1,10'h3a6,TR40, 1);
      add(1,0,0,x1, 1,10'h3a6,TR40, 1);
      add(0,0,0,'0, 1,10'h3a6,TR40, 1);
      for (int i = 0; i < vecs.size(); i++)
         cyc($sformatf("v%0d", i), vecs[i].tvalid, vecs[i].tuser, vecs[i].tlast, vecs[i].tdata,
             vecs[i].exp_valid, vecs[i].exp_sync, vecs[i].exp_data, vecs[i].exp_tready);

      // two-cycle stall mid-line, no horizontal blanking
      param_hblank = 16'd0;
      cyc("st0", 1,1,0,c0, 1,10'h2aa,c0, 1);
      cyc("st1", 1,0,0,c1, 1,10'h035,c1, 1);
      cyc("st2", 0,0,0,x0, 0,10'h000,'0, 1);
      cyc("st3", 0,0,0,x0, 0,10'h000,'0, 1);
      cyc("st4", 1,0,0,c2, 1,10'h035,c2, 1);
      cyc("st5", 1,0,1,c3, 1,10'h12a,c3, 0);
      cyc("st6", 0,0,0,'0, 1,10'h059,c0^c1^c2^c3, 0);
      cyc("st7", 0,0,0,'0, 1,10'h3a6,TR40, 1);

      // one-beat frame of height 1
      param_height = 16'd1;
      cyc("ob0", 1,1,1,d0, 1,10'h2aa,d0, 0);
      cyc("ob1", 0,0,0,'0, 1,10'h059,d0, 0);
      cyc("ob2", 0,0,0,'0, 1,10'h3a6,TR40, 1);
      cyc("ob3", 1,0,0,x0, 1,10'h3a6,TR40, 1);
      cyc("ob4", 0,0,0,'0, 1,10'h3a6,TR40, 1);

      // reset in the middle of a line
      param_height = 16'd2;
      cyc("rl0", 1,1,0,e0, 1,10'h2aa,e0, 1);
      cyc("rl1", 1,0,0,e1, 1,10'h035,e1, 1);
      axis.tvalid = 1'b0;
      reset = 1'b1;
      #1;
      check("rl.valid",  40'(m_valid), 40'(1'b0));
      check("rl.sync",   40'(m_sync), 40'(10'h3a6));
      check("rl.data",   m_data, TR40);
      check("rl.tready", 40'(axis.tready), 40'(1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("rl2", 0,0,0,'0, 1,10'h3a6,TR40, 1);
      cyc("rl3", 1,0,1,x1, 1,10'h3a6,TR40, 1);
      cyc("rl4", 0,0,0,'0, 1,10'h3a6,TR40, 1);
      cyc("rl5", 0,0,0,'0, 1,10'h3a6,TR40, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
